phase_sequencer: RTL and testbench

- Generates the one-hot instruction phase (`phase`) and the halt signal (`hlt`) consumed by the program counter and the other datapath blocks of the multi-cycle CPU.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Stalls on memory busy, supports halting and single-step pause, and counts retired instructions.

---
 rtl/phase_sequencer.sv | 98 +++++++++
 tb/tb_phase_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer for the multi-cycle CPU: one-hot phase, halt,
// single-step pause and a retired-instruction counter. All outputs are registered.
module phase_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             run,
    input  logic             step_mode,
    input  logic             mem_busy,
    input  logic             hlt_req,
    output logic [4:0]       phase,
    output logic             hlt,
    output logic             paused,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_HALT  = 3'd0;
    localparam logic [2:0] S_PAUSE = 3'd1;
    localparam logic [2:0] S_FWAIT = 3'd2;
    localparam logic [2:0] S_F     = 3'd3;
    localparam logic [2:0] S_D     = 3'd4;
    localparam logic [2:0] S_E     = 3'd5;
    localparam logic [2:0] S_M     = 3'd6;
    localparam logic [2:0] S_W     = 3'd7;

    localparam logic [4:0] PH_F = 5'b00001;
    localparam logic [4:0] PH_D = 5'b00010;
    localparam logic [4:0] PH_E = 5'b00100;
    localparam logic [4:0] PH_M = 5'b01000;
    localparam logic [4:0] PH_W = 5'b10000;

    logic [2:0]       state, nxt;
    logic [4:0]       phase_nxt;
    logic             hlt_nxt, paused_nxt;
    logic [2:0]       fetch_entry;

    // Fetch readiness is sampled on the edge that enters fetch, so that PH_F
    // is registered only for the single cycle that actually leaves fetch.
    // A busy memory parks the sequencer in the phase-0 wait sub-state instead.
    always_comb fetch_entry = mem_busy ? S_FWAIT : S_F;

    always_comb begin
        nxt = state;
        case (state)
            S_HALT:  if (run) nxt = fetch_entry;
            S_PAUSE: if (run) nxt = fetch_entry;
            S_FWAIT: if (!mem_busy) nxt = S_F;
            S_F:     nxt = S_D;
            S_D:     nxt = S_E;
            S_E:     nxt = S_M;
            S_M:     if (!mem_busy) nxt = S_W;
            S_W: begin
                if (hlt_req)        nxt = S_HALT;
                else if (step_mode) nxt = S_PAUSE;
                else                nxt = fetch_entry;
            end
            default: nxt = S_HALT;
        endcase
    end

    always_comb begin
        phase_nxt  = 5'b00000;
        hlt_nxt    = 1'b0;
        paused_nxt = 1'b0;
        case (nxt)
            S_HALT:  hlt_nxt    = 1'b1;
            S_PAUSE: paused_nxt = 1'b1;
            S_F:     phase_nxt  = PH_F;
            S_D:     phase_nxt  = PH_D;
            S_E:     phase_nxt  = PH_E;
            S_M:     phase_nxt  = PH_M;
            S_W:     phase_nxt  = PH_W;
            default: phase_nxt  = 5'b00000;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= S_HALT;
            phase   <= 5'b00000;
            hlt     <= 1'b1;
            paused  <= 1'b0;
            retired <= '0;
        end else begin
            state  <= nxt;
            phase  <= phase_nxt;
            hlt    <= hlt_nxt;
            paused <= paused_nxt;
            // W always exits after one cycle, so every W cycle retires one instruction
            if (state == S_W)
                retired <= retired + 1'b1;
            else if (state == S_HALT && run)
                retired <= '0;
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: inputs driven and outputs sampled on the
// falling clock edge, expected values hand-computed.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        run, step_mode, mem_busy, hlt_req;
    logic [4:0]  phase;
    logic        hlt, paused;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    localparam logic [4:0] PH_F = 5'b00001;
    localparam logic [4:0] PH_D = 5'b00010;
    localparam logic [4:0] PH_E = 5'b00100;
    localparam logic [4:0] PH_M = 5'b01000;
    localparam logic [4:0] PH_W = 5'b10000;

    phase_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .n_rst(n_rst), .run(run), .step_mode(step_mode),
        .mem_busy(mem_busy), .hlt_req(hlt_req), .phase(phase), .hlt(hlt),
        .paused(paused), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_phase(input logic [4:0] p);
        int n = 0;
        while (phase !== p && n < 20) begin
            cyc();
            n++;
        end
        chk("wait_phase", {27'd0, phase}, {27'd0, p});
    endtask

    task automatic pulse_run();
        run = 1'b1;
        cyc();
        run = 1'b0;
    endtask

    logic [4:0] seq [5];
    int cnt, mcnt;

    initial begin
        seq[0] = PH_F; seq[1] = PH_D; seq[2] = PH_E; seq[3] = PH_M; seq[4] = PH_W;
        n_rst = 1'b0; run = 1'b0; step_mode = 1'b0; mem_busy = 1'b0; hlt_req = 1'b0;
        cyc(); cyc();
        chk("rst_phase", {27'd0, phase}, 32'd0);
        chk("rst_hlt", {31'd0, hlt}, 32'd1);
        chk("rst_paused", {31'd0, paused}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        n_rst = 1'b1;
        cyc();
        chk("halt_idle", {31'd0, hlt}, 32'd1);

        // free-run: three back-to-back instructions, no gaps
        pulse_run();
        chk("run_hlt_low", {31'd0, hlt}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("seq%0d", i), {27'd0, phase}, {27'd0, seq[i % 5]});
            cyc();
        end
        chk("retired3", retired, 32'd3);
        chk("next_f", {27'd0, phase}, {27'd0, PH_F});

        // fetch stall: busy on entry for 4 edges -> 4 cycles of phase 0, one PH_F
        wait_phase(PH_W);
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("fwait%0d", i), {27'd0, phase}, 32'd0);
        end
        mem_busy = 1'b0;
        cyc();
        chk("fstall_f", {27'd0, phase}, {27'd0, PH_F});
        cyc();
        chk("fstall_d", {27'd0, phase}, {27'd0, PH_D});

        // memory stall: 3 busy edges in M -> 4 PH_M cycles, 8-cycle instruction
        wait_phase(PH_F);
        cnt = 1; mcnt = 0;
        while (phase !== PH_W && cnt < 20) begin
            if (phase === PH_E) mem_busy = 1'b1;
            if (phase === PH_M) begin
                mcnt++;
                if (mcnt == 4) mem_busy = 1'b0;
            end
            cyc();
            cnt++;
        end
        chk("m_count", mcnt, 32'd4);
        chk("m_latency", cnt, 32'd8);
        mem_busy = 1'b0;

        // halt from W, then restart clears retired
        hlt_req = 1'b1;
        cyc();
        hlt_req = 1'b0;
        chk("halt1_hlt", {31'd0, hlt}, 32'd1);
        chk("halt1_phase", {27'd0, phase}, 32'd0);
        pulse_run();
        chk("restart_retired", retired, 32'd0);
        chk("restart_f", {27'd0, phase}, {27'd0, PH_F});

        // hlt_req in W beats step_mode
        step_mode = 1'b1;
        wait_phase(PH_W);
        cyc();
        chk("pause_paused", {31'd0, paused}, 32'd1);
        chk("pause_retired", retired, 32'd1);
        pulse_run();
        wait_phase(PH_W);
        hlt_req = 1'b1;
        cyc();
        hlt_req = 1'b0;
        chk("hltprio_hlt", {31'd0, hlt}, 32'd1);
        chk("hltprio_paused", {31'd0, paused}, 32'd0);
        chk("hltprio_phase", {27'd0, phase}, 32'd0);
        chk("hltprio_retired", retired, 32'd2);
        pulse_run();
        chk("hltrun_retired", retired, 32'd0);
        chk("hltrun_f", {27'd0, phase}, {27'd0, PH_F});

        // single-step: pause after every W, hlt_req in PAUSE ignored
        for (int k = 1; k <= 3; k++) begin
            wait_phase(PH_W);
            cyc();
            chk($sformatf("step%0d_paused", k), {31'd0, paused}, 32'd1);
            chk($sformatf("step%0d_phase", k), {27'd0, phase}, 32'd0);
            chk($sformatf("step%0d_hlt", k), {31'd0, hlt}, 32'd0);
            chk($sformatf("step%0d_retired", k), retired, k);
            hlt_req = 1'b1;
            cyc();
            hlt_req = 1'b0;
            chk($sformatf("step%0d_hold", k), {31'd0, paused}, 32'd1);
            pulse_run();
            chk($sformatf("step%0d_resume", k), {27'd0, phase}, {27'd0, PH_F});
        end

        // asynchronous reset in PH_E, off the clock edge
        wait_phase(PH_E);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_phase", {27'd0, phase}, 32'd0);
        chk("arst_hlt", {31'd0, hlt}, 32'd1);
        chk("arst_retired", retired, 32'd0);
        cyc();
        n_rst = 1'b1;
        cyc();
        chk("arst_hold", {31'd0, hlt}, 32'd1);
        pulse_run();
        chk("arst_run_f", {27'd0, phase}, {27'd0, PH_F});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
